// File: rtl/cfg_readout_pkg.sv
// Word map, FSM state and feature-bit indices for the configuration readout unit.
package cfg_readout_pkg;

    localparam int unsigned ADDR_MAGIC   = 'h00;
    localparam int unsigned ADDR_FEAT    = 'h01;
    localparam int unsigned ADDR_SIZES   = 'h02;
    localparam int unsigned ADDR_PRED    = 'h03;
    localparam int unsigned ADDR_HALT    = 'h04;
    localparam int unsigned ADDR_EXC     = 'h05;
    localparam int unsigned ADDR_DM      = 'h06;
    localparam int unsigned ADDR_RULECNT = 'h07;
    localparam int unsigned TABLE_BASE [6] = '{'h10, 'h20, 'h30, 'h40, 'h50, 'h60};
    localparam int unsigned TABLE_SIZE     = 16;
    localparam int unsigned ADDR_DUMP_LAST = 'h6F;

    localparam logic [63:0] MAGIC = 64'h4356_4136_4346_4701;

    typedef enum logic [3:0] {
        FEAT_FPU_EN, FEAT_XF16, FEAT_XF16ALT, FEAT_XF8, FEAT_RVA, FEAT_RVV,
        FEAT_RVC, FEAT_RVZCB, FEAT_XFVEC, FEAT_CVXIF_EN, FEAT_ZICOND_EN,
        FEAT_RVS, FEAT_RVU, FEAT_DEBUG_EN, FEAT_NON_IDEMPOTENCE_EN, FEAT_AXI_BURST_WRITE_EN
    } feat_idx_e;

    typedef enum logic {IDLE, DUMP} fsm_state_e;

    function automatic logic is_mapped(input int unsigned addr);
        return (addr <= ADDR_RULECNT) ||
               (addr >= TABLE_BASE[0] && addr < TABLE_BASE[5] + TABLE_SIZE);
    endfunction

endpackage

// File: rtl/config_pkg.sv
// Minimal CVA6 configuration type carrying the fields the readout unit exposes.
package config_pkg;

    typedef struct packed {
        bit              FpuEn;
        bit              XF16;
        bit              XF16ALT;
        bit              XF8;
        bit              RVA;
        bit              RVV;
        bit              RVC;
        bit              RVZCB;
        bit              XFVec;
        bit              CvxifEn;
        bit              ZiCondExtEn;
        bit              RVS;
        bit              RVU;
        bit              DebugEn;
        bit              NonIdemPotenceEn;
        bit              AxiBurstWriteEn;
        int unsigned     NrCommitPorts;
        int unsigned     AxiIdWidth;
        int unsigned     AxiAddrWidth;
        int unsigned     AxiDataWidth;
        int unsigned     AxiUserWidth;
        int unsigned     NrLoadBufEntries;
        int unsigned     MaxOutstandingStores;
        int unsigned     NrPMPEntries;
        int unsigned     RASDepth;
        int unsigned     BTBEntries;
        int unsigned     BHTEntries;
        int unsigned     NOCType;
        logic [63:0]     HaltAddress;
        logic [63:0]     ExceptionAddress;
        logic [63:0]     DmBaseAddress;
        int unsigned     NrNonIdempotentRules;
        logic [1023:0]   NonIdempotentAddrBase;
        logic [1023:0]   NonIdempotentLength;
        int unsigned     NrExecuteRegionRules;
        logic [1023:0]   ExecuteRegionAddrBase;
        logic [1023:0]   ExecuteRegionLength;
        int unsigned     NrCachedRegionRules;
        logic [1023:0]   CachedRegionAddrBase;
        logic [1023:0]   CachedRegionLength;
    } cva6_cfg_t;

endpackage

// File: rtl/cva6_config_pkg.sv
// Default elaborated core configuration.
package cva6_config_pkg;

    localparam config_pkg::cva6_cfg_t cva6_cfg = '{
        FpuEn: 1'b1, XF16: 1'b1, XF16ALT: 1'b1, XF8: 1'b1, RVA: 1'b1, RVV: 1'b1,
        RVC: 1'b1, RVZCB: 1'b1, XFVec: 1'b1, CvxifEn: 1'b1, ZiCondExtEn: 1'b1,
        RVS: 1'b1, RVU: 1'b1, DebugEn: 1'b1, NonIdemPotenceEn: 1'b0, AxiBurstWriteEn: 1'b0,
        NrCommitPorts: 2, AxiIdWidth: 4, AxiAddrWidth: 64, AxiDataWidth: 64, AxiUserWidth: 1,
        NrLoadBufEntries: 2, MaxOutstandingStores: 7, NrPMPEntries: 8,
        RASDepth: 2, BTBEntries: 32, BHTEntries: 128, NOCType: 1,
        HaltAddress: 64'h800, ExceptionAddress: 64'h808, DmBaseAddress: 64'h0,
        NrNonIdempotentRules: 2,
        NonIdempotentAddrBase: 1024'({64'h0, 64'h0}),
        NonIdempotentLength: 1024'({64'h0, 64'h0}),
        NrExecuteRegionRules: 3,
        ExecuteRegionAddrBase: 1024'({64'h8000_0000, 64'h1_0000, 64'h0}),
        ExecuteRegionLength: 1024'({64'h4000_0000, 64'h1_0000, 64'h1000}),
        NrCachedRegionRules: 1,
        CachedRegionAddrBase: 1024'({64'h8000_0000}),
        CachedRegionLength: 1024'({64'h4000_0000})
    };

endpackage

// File: rtl/cfg_readout_encode.sv
// Combinational word-address to configuration-word encoder.
module cfg_readout_encode
    import cfg_readout_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = cva6_config_pkg::cva6_cfg,
    parameter int unsigned AddrWidth = 7
) (
    input  logic [AddrWidth-1:0] addr,
    output logic [63:0]          data,
    output logic                 err
);

    // Entries at or beyond the populated rule count read as zero without error.
    function automatic logic [63:0] rule(input logic [1023:0] tab, input int unsigned cnt,
                                         input logic [3:0] i);
        return (32'(i) < cnt) ? tab[64*i +: 64] : '0;
    endfunction

    logic [15:0]  feat;
    int unsigned  a;

    always_comb begin
        feat = '0;
        feat[FEAT_FPU_EN]             = CVA6Cfg.FpuEn;
        feat[FEAT_XF16]               = CVA6Cfg.XF16;
        feat[FEAT_XF16ALT]            = CVA6Cfg.XF16ALT;
        feat[FEAT_XF8]                = CVA6Cfg.XF8;
        feat[FEAT_RVA]                = CVA6Cfg.RVA;
        feat[FEAT_RVV]                = CVA6Cfg.RVV;
        feat[FEAT_RVC]                = CVA6Cfg.RVC;
        feat[FEAT_RVZCB]              = CVA6Cfg.RVZCB;
        feat[FEAT_XFVEC]              = CVA6Cfg.XFVec;
        feat[FEAT_CVXIF_EN]           = CVA6Cfg.CvxifEn;
        feat[FEAT_ZICOND_EN]          = CVA6Cfg.ZiCondExtEn;
        feat[FEAT_RVS]                = CVA6Cfg.RVS;
        feat[FEAT_RVU]                = CVA6Cfg.RVU;
        feat[FEAT_DEBUG_EN]           = CVA6Cfg.DebugEn;
        feat[FEAT_NON_IDEMPOTENCE_EN] = CVA6Cfg.NonIdemPotenceEn;
        feat[FEAT_AXI_BURST_WRITE_EN] = CVA6Cfg.AxiBurstWriteEn;
    end

    always_comb begin
        a    = 32'(addr);
        data = '0;
        err  = 1'b0;
        if (!is_mapped(a)) begin
            err = 1'b1;
        end else if (a <= ADDR_RULECNT) begin
            case (a)
                ADDR_MAGIC:   data = MAGIC;
                ADDR_FEAT:    data = 64'(feat);
                ADDR_SIZES:   data = {8'(CVA6Cfg.NrPMPEntries), 8'(CVA6Cfg.MaxOutstandingStores),
                                      8'(CVA6Cfg.NrLoadBufEntries), 8'(CVA6Cfg.AxiUserWidth),
                                      8'(CVA6Cfg.AxiDataWidth), 8'(CVA6Cfg.AxiAddrWidth),
                                      8'(CVA6Cfg.AxiIdWidth), 8'(CVA6Cfg.NrCommitPorts)};
                ADDR_PRED:    data = {8'h00, 8'(CVA6Cfg.NOCType), 16'(CVA6Cfg.BHTEntries),
                                      16'(CVA6Cfg.BTBEntries), 16'(CVA6Cfg.RASDepth)};
                ADDR_HALT:    data = CVA6Cfg.HaltAddress;
                ADDR_EXC:     data = CVA6Cfg.ExceptionAddress;
                ADDR_DM:      data = CVA6Cfg.DmBaseAddress;
                ADDR_RULECNT: data = {40'h0, 8'(CVA6Cfg.NrCachedRegionRules),
                                      8'(CVA6Cfg.NrExecuteRegionRules),
                                      8'(CVA6Cfg.NrNonIdempotentRules)};
                default:      data = '0;
            endcase
        end else begin
            case ((a - TABLE_BASE[0]) / TABLE_SIZE)
                0: data = rule(CVA6Cfg.NonIdempotentAddrBase, CVA6Cfg.NrNonIdempotentRules, a[3:0]);
                1: data = rule(CVA6Cfg.NonIdempotentLength, CVA6Cfg.NrNonIdempotentRules, a[3:0]);
                2: data = rule(CVA6Cfg.ExecuteRegionAddrBase, CVA6Cfg.NrExecuteRegionRules, a[3:0]);
                3: data = rule(CVA6Cfg.ExecuteRegionLength, CVA6Cfg.NrExecuteRegionRules, a[3:0]);
                4: data = rule(CVA6Cfg.CachedRegionAddrBase, CVA6Cfg.NrCachedRegionRules, a[3:0]);
                5: data = rule(CVA6Cfg.CachedRegionLength, CVA6Cfg.NrCachedRegionRules, a[3:0]);
                default: data = '0;
            endcase
        end
    end

endmodule

// File: rtl/cfg_readout_unit.sv
// Read-only responder exposing the core configuration; single reads or full-map dump.
module cfg_readout_unit
    import cfg_readout_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = cva6_config_pkg::cva6_cfg,
    parameter int unsigned AddrWidth = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 dump_start_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [63:0]          rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 rsp_last_o,
    output logic                 busy_o
);

    fsm_state_e           state_q, state_d;
    logic [AddrWidth-1:0] cnt_q, cnt_d, enc_addr;
    logic [63:0]          enc_data;
    logic                 enc_err, load, load_ok, last_d;

    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] cur);
        return (32'(cur) == ADDR_RULECNT) ? AddrWidth'(TABLE_BASE[0]) : cur + 1'b1;
    endfunction

    cfg_readout_encode #(
        .CVA6Cfg  (CVA6Cfg),
        .AddrWidth(AddrWidth)
    ) u_encode (
        .addr(enc_addr),
        .data(enc_data),
        .err (enc_err)
    );

    always_comb begin
        load_ok     = !rsp_valid_o || rsp_ready_i;
        state_d     = state_q;
        cnt_d       = cnt_q;
        enc_addr    = req_addr_i;
        load        = 1'b0;
        last_d      = 1'b0;
        req_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start_i) begin
                    // Word 0 loads on the start edge when the output slot is free.
                    state_d  = DUMP;
                    enc_addr = '0;
                    load     = load_ok;
                    cnt_d    = load_ok ? next_addr('0) : '0;
                end else begin
                    req_ready_o = load_ok;
                    load        = req_valid_i && load_ok;
                end
            end
            DUMP: begin
                enc_addr = cnt_q;
                if (load_ok) begin
                    load = 1'b1;
                    if (32'(cnt_q) == ADDR_DUMP_LAST) begin
                        last_d  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = next_addr(cnt_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            rsp_last_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                rsp_valid_o <= 1'b1;
                rsp_data_o  <= enc_data;
                rsp_err_o   <= enc_err;
                rsp_last_o  <= last_d;
            end else if (rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
                rsp_last_o  <= 1'b0;
            end
        end
    end

    assign busy_o = (state_q == DUMP) || (rsp_valid_o && rsp_last_o);

endmodule
